sprite_mover: RTL and testbench

Per-sprite motion controller sitting directly upstream of the sprite pixel-address generator. Once per video frame it advances the sprite's top-left position (`loc_h`, `loc_v`). Horizontal position wraps modulo the 850-pixel logical screen width, matching the address generator's wrap handling. An optional jump state machine drives the vertical position.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_mover_if.sv | 23 ++
 rtl/sprite_mover_wrap_step.sv | 30 +++
 rtl/sprite_mover.sv | 126 ++++++++++++
 tb/tb_sprite_mover.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: constants and types shared by the sprite motion controller and
// the sprite pixel-address generator.
package sprite_pkg;

  // Logical line width; loc_h wraps modulo this value.
  localparam int SCREEN_W = 850;

  // Width of the vertical velocity register.
  localparam int VEL_W = 4;

  typedef enum logic [1:0] {
    GROUND,
    RISE,
    FALL
  } jump_state_t;

endpackage

// File: rtl/sprite_mover_if.sv
// sprite_mover_if: per-frame control inputs and registered position outputs
// of one sprite. The master drives controls; the slave (sprite_mover) drives
// the position.
interface sprite_mover_if;
  logic       frame_tick;
  logic       en;
  logic       dir;
  logic [2:0] speed;
  logic       jump;
  logic [9:0] loc_h;
  logic [9:0] loc_v;
  logic       airborne;

  modport master (
    output frame_tick, en, dir, speed, jump,
    input  loc_h, loc_v, airborne
  );

  modport slave (
    input  frame_tick, en, dir, speed, jump,
    output loc_h, loc_v, airborne
  );
endinterface

// File: rtl/sprite_mover_wrap_step.sv
// wrap_step: combinational +/- step modulo W. pos must already be in 0..W-1
// and step < W, so a single conditional correction keeps the result in range.
// Reusable by any horizontally scrolling layer.
module wrap_step
  import sprite_pkg::*;
#(
  parameter int W = SCREEN_W
) (
  input  logic [9:0] pos,
  input  logic [2:0] step,
  input  logic       dir,
  output logic [9:0] nxt
);

  logic [10:0] sum;

  // Forward step with overflow fold, or backward step with underflow fold.
  always_comb begin
    // NOTE: every output gets a value on every path so no latch is inferred.
    sum = {1'b0, pos} + {8'd0, step};
    nxt = pos;
    if (!dir) begin
      nxt = (sum >= 11'(W)) ? 10'(sum - 11'(W)) : sum[9:0];
    end else begin
      nxt = (pos < {7'd0, step}) ? 10'({1'b0, pos} + 11'(W) - {8'd0, step})
                                 : pos - {7'd0, step};
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: once-per-frame sprite position update. loc_h steps by speed
// and wraps modulo SCREEN_W; loc_v follows an optional jump state machine.
// Optional feature macro: SPRITE_MOVER_JUMP_EN (jump edge latch and
// RISE/FALL FSM). Without it loc_v is fixed at GROUND_V and airborne is 0.
module sprite_mover #(
  parameter int SCREEN_W = sprite_pkg::SCREEN_W,
  parameter int H_START  = 0,
  parameter int GROUND_V = 300,
  parameter int JUMP_V0  = 8,
  parameter int VMAX     = 8
) (
  input logic           clk,
  input logic           rst,
  sprite_mover_if.slave bus
);
  import sprite_pkg::*;

  logic       step_en;
  logic [9:0] h_next;

  assign step_en = bus.frame_tick & bus.en;

  wrap_step #(.W(SCREEN_W)) u_wrap_step (
    .pos  (bus.loc_h),
    .step (bus.speed),
    .dir  (bus.dir),
    .nxt  (h_next)
  );

  // Horizontal position register, advanced once per enabled frame tick.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    if (!rst) begin
      bus.loc_h <= 10'(H_START);
    end else if (step_en) begin
      bus.loc_h <= h_next;
    end
  end

`ifdef SPRITE_MOVER_JUMP_EN
  jump_state_t      state;
  logic [VEL_W-1:0] vel;
  logic [VEL_W-1:0] vel_up;
  logic [10:0]      fall_v;
  logic [9:0]       loc_v_q;
  logic             air_q;
  logic             jump_q;
  logic             pend;
  logic             jump_rise;

  assign jump_rise = bus.jump & ~jump_q;

  // Falling velocity saturates at VMAX; candidate row uses the new velocity.
  always_comb begin
    vel_up = (vel >= VEL_W'(VMAX)) ? VEL_W'(VMAX) : vel + 1'b1;
    fall_v = {1'b0, loc_v_q} + 11'(vel_up);
  end

  // Jump edge latch: edges while paused are discarded, and every enabled
  // tick clears the latch so presses made in the air never queue a re-jump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jump_q <= 1'b0;
      pend   <= 1'b0;
    end else begin
      jump_q <= bus.jump;
      if (step_en)                  pend <= 1'b0;
      else if (bus.en && jump_rise) pend <= 1'b1;
    end
  end

  // Vertical FSM with registered loc_v and airborne.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= GROUND;
      vel     <= '0;
      loc_v_q <= 10'(GROUND_V);
      air_q   <= 1'b0;
    end else if (step_en) begin
      case (state)
        GROUND: begin
          if (pend || jump_rise) begin
            state <= RISE;
            vel   <= VEL_W'(JUMP_V0);
            air_q <= 1'b1;
          end
        end
        RISE: begin
          loc_v_q <= loc_v_q - 10'(vel);
          if (vel == VEL_W'(1)) begin
            state <= FALL;
            vel   <= '0;
          end else begin
            vel <= vel - 1'b1;
          end
        end
        FALL: begin
          if (fall_v >= 11'(GROUND_V)) begin
            loc_v_q <= 10'(GROUND_V);
            state   <= GROUND;
            vel     <= '0;
            air_q   <= 1'b0;
          end else begin
            loc_v_q <= fall_v[9:0];
            vel     <= vel_up;
          end
        end
        default: begin
          state   <= GROUND;
          vel     <= '0;
          loc_v_q <= 10'(GROUND_V);
          air_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.loc_v    = loc_v_q;
  assign bus.airborne = air_q;
`else
  assign bus.loc_v    = 10'(GROUND_V);
  assign bus.airborne = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed stimulus for sprite_mover. Each frame tick pushes
// its hand-computed expected position into a scoreboard; a monitor pops and
// compares on the falling edge after every tick the DUT sampled.
module tb_sprite_mover;

  typedef struct {
    int h;
    int v;
    bit a;
  } exp_t;

`ifdef SPRITE_MOVER_JUMP_EN
  localparam bit JE = 1'b1;
`else
  localparam bit JE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tick_seen;
  int   total = 0;
  int   bad   = 0;
  int   tick_no = 0;
  int   pop_no  = 0;
  exp_t sb[$];

  // Expected rise/fall rows after each of the 16 airborne ticks.
  int jseq [16] = '{292, 285, 279, 274, 270, 267, 265, 264,
                    265, 267, 270, 274, 279, 285, 292, 300};

  sprite_mover_if bus ();

  sprite_mover dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected values when the jump feature is compiled out.
  function automatic int ev(input int v);
    return JE ? v : 300;
  endfunction

  function automatic bit ea(input bit a);
    return JE ? a : 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Issue one frame tick from a falling edge with current control inputs.
  task automatic tick(input int h, input int v, input bit a);
    exp_t e;
    e.h = h;
    e.v = ev(v);
    e.a = ea(a);
    sb.push_back(e);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  // Marks the cycle after the DUT sampled a tick.
  always @(posedge clk or negedge rst) begin
    if (!rst) tick_seen <= 1'b0;
    else      tick_seen <= bus.frame_tick;
  end

  // Monitor: compare DUT outputs against the oldest expected entry.
  always @(negedge clk) begin
    if (tick_seen) begin
      pop_no++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard underflow at tick %0d", pop_no);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("loc_h[%0d]", pop_no), int'(bus.loc_h), e.h);
        check($sformatf("loc_v[%0d]", pop_no), int'(bus.loc_v), e.v);
        check($sformatf("airborne[%0d]", pop_no), int'(bus.airborne), int'(e.a));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b0;
    bus.frame_tick = 1'b0;
    bus.en         = 1'b1;
    bus.dir        = 1'b0;
    bus.speed      = 3'd0;
    bus.jump       = 1'b0;
    #12;
    check("reset loc_h", int'(bus.loc_h), 0);
    check("reset loc_v", int'(bus.loc_v), 300);
    check("reset airborne", int'(bus.airborne), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Horizontal stepping and wrap in both directions.
    bus.dir = 1'b1; bus.speed = 3'd4; tick(846, 300, 0);
    bus.dir = 1'b0; bus.speed = 3'd5; tick(1, 300, 0);
    tick(6, 300, 0);
    bus.dir = 1'b1; bus.speed = 3'd4; tick(2, 300, 0);
    bus.speed = 3'd5; tick(847, 300, 0);
    bus.speed = 3'd0; tick(847, 300, 0);

    // Full jump, launched on the same tick as a right wrap.
    bus.dir = 1'b0; bus.speed = 3'd3; bus.jump = 1'b1;
    tick(0, 300, 1);
    bus.speed = 3'd0;
    for (int i = 0; i < 16; i++) tick(0, jseq[i], i < 15);

    // Second jump with presses in the air: trajectory unchanged, no re-jump.
    bus.jump = 1'b0;
    @(negedge clk);
    bus.jump = 1'b1;
    tick(0, 300, 1);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        bus.jump = 1'b0;
        @(negedge clk);
        bus.jump = 1'b1;
      end
      if (i == 6) begin
        bus.jump = 1'b0;
        @(negedge clk);
        bus.jump = 1'b1;
        @(negedge clk);
      end
      tick(0, jseq[i], i < 15);
    end
    for (int i = 0; i < 3; i++) tick(0, 300, 0);

    // Pause: ticks and a jump edge while en=0 change nothing.
    bus.en = 1'b0; bus.speed = 3'd5; bus.jump = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) bus.jump = 1'b1;
      tick(0, 300, 0);
    end
    bus.en = 1'b1;
    tick(5, 300, 0);

    // Reset asserted mid-jump at loc_v=270.
    bus.speed = 3'd0; bus.jump = 1'b0;
    @(negedge clk);
    bus.jump = 1'b1;
    tick(5, 300, 1);
    for (int i = 0; i < 5; i++) tick(5, jseq[i], 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async reset loc_h", int'(bus.loc_h), 0);
    check("async reset loc_v", int'(bus.loc_v), 300);
    check("async reset airborne", int'(bus.airborne), 0);
    bus.jump = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.speed = 3'd1;
    tick(1, 300, 0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
